// File: rtl/fact_seq_ctrl.sv
// Factorial sequencer: drives a down-counter and product register until Q <= 1.
// Moore outputs registered alongside state; DONE at cycle 2n+1 (3 when n <= 1); no backpressure, GO only sampled in IDLE.
module fact_seq_ctrl #(
   parameter int Data_width = 4,
   parameter int MAX_N      = 12
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  GO,
   input  logic [Data_width-1:0] N,
   input  logic [Data_width-1:0] CNT_Q,
   output logic [Data_width-1:0] CNT_D,
   output logic                  CNT_LD,
   output logic                  CNT_UD,
   output logic                  CNT_CE,
   output logic                  REG_LD,
   output logic                  REG_SEL,
   output logic                  OE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_MULT  = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam logic [Data_width-1:0] max_n_c = MAX_N[Data_width-1:0];
   localparam logic [Data_width-1:0] one_c   = {{(Data_width-1){1'b0}}, 1'b1};

   state_t                  st;
   state_t                  nxt;
   logic [Data_width-1:0]   n_q;
   // {cnt_ld, cnt_ud, cnt_ce, reg_ld, reg_sel, oe, busy, done, error}
   logic [8:0]              dec;
   logic [8:0]              outs_q;

   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:  if (GO) nxt = S_LOAD;
         S_LOAD:  nxt = S_CHECK;
         S_CHECK: begin
            if (n_q > max_n_c)      nxt = S_ERR;
            else if (CNT_Q > one_c) nxt = S_MULT;
            else                    nxt = S_DONE;
         end
         S_MULT:  nxt = S_CHECK;
         S_DONE:  if (!GO) nxt = S_IDLE;
         S_ERR:   if (!GO) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copy always matches st.
   always_comb begin
      dec = 9'b0;
      case (nxt)
         S_LOAD:  dec = 9'b1_0_1_1_0_0_1_0_0;
         S_CHECK: dec = 9'b0_0_0_0_0_0_1_0_0;
         S_MULT:  dec = 9'b0_0_1_1_1_0_1_0_0;
         S_DONE:  dec = 9'b0_0_0_0_0_1_0_1_0;
         S_ERR:   dec = 9'b0_0_0_0_0_0_0_0_1;
         default: dec = 9'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         st     <= S_IDLE;
         n_q    <= '0;
         outs_q <= '0;
      end else begin
         st     <= nxt;
         outs_q <= dec;
         if (st == S_IDLE && GO)
            n_q <= N;
      end
   end

   assign CNT_D   = n_q;
   assign CNT_LD  = outs_q[8];
   assign CNT_UD  = outs_q[7];
   assign CNT_CE  = outs_q[6];
   assign REG_LD  = outs_q[5];
   assign REG_SEL = outs_q[4];
   assign OE      = outs_q[3];
   assign BUSY    = outs_q[2];
   assign DONE    = outs_q[1];
   assign ERROR   = outs_q[0];

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Directed bench for fact_seq_ctrl with a behavioural down-counter and product register attached.
module tb_fact_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        GO;
   logic [3:0]  N;
   logic [3:0]  CNT_Q;
   logic [3:0]  CNT_D;
   logic        CNT_LD, CNT_UD, CNT_CE, REG_LD, REG_SEL, OE, BUSY, DONE, ERROR;
   logic [31:0] prod;

   int passed = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   fact_seq_ctrl #(.Data_width(4), .MAX_N(12)) dut (
      .CLK(CLK), .RST(RST), .GO(GO), .N(N), .CNT_Q(CNT_Q), .CNT_D(CNT_D),
      .CNT_LD(CNT_LD), .CNT_UD(CNT_UD), .CNT_CE(CNT_CE), .REG_LD(REG_LD),
      .REG_SEL(REG_SEL), .OE(OE), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
   );

   always_ff @(posedge CLK) begin
      if (CNT_CE) begin
         if (CNT_LD)      CNT_Q <= CNT_D;
         else if (CNT_UD) CNT_Q <= CNT_Q + 4'd1;
         else             CNT_Q <= CNT_Q - 4'd1;
      end
      if (REG_LD)
         prod <= REG_SEL ? prod * {28'd0, CNT_Q} : 32'd1;
   end

   function automatic logic [8:0] outv();
      return {CNT_LD, CNT_UD, CNT_CE, REG_LD, REG_SEL, OE, BUSY, DONE, ERROR};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Launches a run and observes it until DONE/ERROR or a 60-cycle budget; c counts cycles after the GO edge.
   task automatic run(input logic [3:0] n, input logic [3:0] n_mid, input int stop_at,
                      output int end_cyc, output int mults, output logic [63:0] ce_mask,
                      output int ud_bad, output int d_bad, output logic load_c1);
      GO = 1'b1; N = n;
      tick();
      N = n_mid;
      end_cyc = -1; mults = 0; ce_mask = '0; ud_bad = 0; d_bad = 0; load_c1 = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (c == 1) load_c1 = CNT_LD && CNT_CE && REG_LD && !REG_SEL && BUSY;
         if (CNT_CE) ce_mask[c] = 1'b1;
         if (REG_LD && REG_SEL) mults++;
         if (CNT_UD !== 1'b0) ud_bad++;
         if (CNT_D !== n) d_bad++;
         if (DONE || ERROR || c == stop_at) begin
            end_cyc = c;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; GO = 1'b1; N = 4'd5;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (outv() !== 9'b0) $display("FAIL reset_cycle%0d outputs=%b want=%b", i, outv(), 9'b0);
         else passed++;
      end
      RST = 1'b0; GO = 1'b0;
      tick();
      total++;
      if (outv() !== 9'b0 || CNT_D !== 4'd0) $display("FAIL reset_idle outputs=%b cnt_d=%0d want 0/0", outv(), CNT_D);
      else passed++;
   endtask

   task automatic test_n5();
      int e, m, ub, db; logic [63:0] ce; logic l1;
      run(4'd5, 4'd5, 0, e, m, ce, ub, db, l1);
      total++; if (l1 !== 1'b1) $display("FAIL n5_load_c1 got=%b want=1", l1); else passed++;
      total++; if (ce !== 64'h2AA) $display("FAIL n5_ce_mask got=%h want=%h", ce, 64'h2AA); else passed++;
      total++; if (e !== 11) $display("FAIL n5_done_cycle got=%0d want=11", e); else passed++;
      total++; if (prod !== 32'd120 || CNT_Q !== 4'd1) $display("FAIL n5_result prod=%0d q=%0d want 120/1", prod, CNT_Q); else passed++;
      total++; if (outv() !== 9'b000001010) $display("FAIL n5_done_outs got=%b want=%b", outv(), 9'b000001010); else passed++;
      tick(); tick(); tick();
      total++; if (DONE !== 1'b1 || BUSY !== 1'b0) $display("FAIL n5_go_hold done=%b busy=%b want 1/0", DONE, BUSY); else passed++;
      GO = 1'b0;
      tick();
      total++; if (outv() !== 9'b0) $display("FAIL n5_idle outputs=%b want=0", outv()); else passed++;
   endtask

   task automatic test_n0_n1();
      int e, m, ub, db; logic [63:0] ce; logic l1;
      for (int k = 0; k < 2; k++) begin
         run(4'(k), 4'(k), 0, e, m, ce, ub, db, l1);
         total++;
         if (e !== 3 || m !== 0) $display("FAIL n%0d_timing done=%0d mults=%0d want 3/0", k, e, m); else passed++;
         total++;
         if (prod !== 32'd1 || OE !== 1'b1 || DONE !== 1'b1) $display("FAIL n%0d_result prod=%0d oe=%b done=%b want 1/1/1", k, prod, OE, DONE);
         else passed++;
         GO = 1'b0;
         tick();
      end
   endtask

   task automatic test_err();
      int e, m, ub, db; logic [63:0] ce; logic l1;
      run(4'd13, 4'd13, 0, e, m, ce, ub, db, l1);
      total++; if (e !== 3 || m !== 0) $display("FAIL n13_timing err=%0d mults=%0d want 3/0", e, m); else passed++;
      total++; if (outv() !== 9'b000000001 || prod !== 32'd1) $display("FAIL n13_outs got=%b prod=%0d want=%b/1", outv(), prod, 9'b000000001); else passed++;
      GO = 1'b0;
      tick();
      total++; if (outv() !== 9'b0) $display("FAIL n13_idle outputs=%b want=0", outv()); else passed++;
   endtask

   task automatic test_n12_mid_n();
      int e, m, ub, db; logic [63:0] ce; logic l1;
      run(4'd12, 4'd7, 0, e, m, ce, ub, db, l1);
      total++; if (e !== 25 || m !== 11) $display("FAIL n12_timing done=%0d mults=%0d want 25/11", e, m); else passed++;
      total++; if (ub !== 0 || db !== 0) $display("FAIL n12_ud_d ud_bad=%0d d_bad=%0d want 0/0", ub, db); else passed++;
      total++; if (prod !== 32'd479001600) $display("FAIL n12_prod got=%0d want=479001600", prod); else passed++;
      GO = 1'b0;
      tick();
   endtask

   task automatic test_reset_midrun();
      int e, m, ub, db; logic [63:0] ce; logic l1;
      run(4'd5, 4'd5, 6, e, m, ce, ub, db, l1);
      RST = 1'b1; GO = 1'b0;
      tick();
      total++; if (outv() !== 9'b0 || CNT_D !== 4'd0) $display("FAIL midrst_outs outputs=%b cnt_d=%0d want 0/0", outv(), CNT_D); else passed++;
      RST = 1'b0;
      tick();
      run(4'd3, 4'd3, 0, e, m, ce, ub, db, l1);
      total++; if (e !== 7 || prod !== 32'd6) $display("FAIL midrst_rerun done=%0d prod=%0d want 7/6", e, prod); else passed++;
      GO = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int e, m, ub, db; logic [63:0] ce; logic l1;
      run(4'd2, 4'd2, 0, e, m, ce, ub, db, l1);
      GO = 1'b0;
      tick();
      run(4'd4, 4'd4, 0, e, m, ce, ub, db, l1);
      total++; if (e !== 9 || prod !== 32'd24) $display("FAIL b2b_second done=%0d prod=%0d want 9/24", e, prod); else passed++;
      GO = 1'b0;
      tick();
   endtask

   initial begin
      GO = 1'b0; N = 4'd0; RST = 1'b1;
      test_reset();
      test_n5();
      test_n0_n1();
      test_err();
      test_n12_mid_n();
      test_reset_midrun();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fact_seq_ctrl.md
# fact_seq_ctrl

Sequencing controller for the factorial engine. It is the control end of the up/down counter interface: it drives the counter's D, LD, UD and CE inputs, reads the counter's Q back, and steps a separate product register (load 1, then multiply by Q) until Q ≤ 1. It sits between the bus-side GO/N request and the datapath, and reports BUSY, DONE and ERROR status.

## Interface
- Data_width, 4: width of N, CNT_D and CNT_Q.
- MAX_N, 12: largest accepted operand; a latched N greater than MAX_N raises ERROR.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- GO  in  1  start request; level-sensitive, sampled only in IDLE.
- N  in  Data_width  operand; captured in IDLE on the edge where GO=1.
- CNT_Q  in  Data_width  current counter value.
- CNT_D  out  Data_width  counter load value; equals the latched operand n_q.
- CNT_LD  out  1  counter load enable.
- CNT_UD  out  1  counter direction; constant 0 (DOWN).
- CNT_CE  out  1  counter clock enable.
- REG_LD  out  1  product register load enable.
- REG_SEL  out  1  product register source: 0 loads constant 1, 1 loads reg×CNT_Q.
- OE  out  1  product output enable.
- BUSY  out  1  high in LOAD, CHECK and MULT.
- DONE  out  1  computation complete.
- ERROR  out  1  operand out of range.

## Operation
- Moore FSM with a registered state; all outputs decode from state only, except CNT_D = n_q.
- Six states: IDLE, LOAD, CHECK, MULT, DONE, ERR.
- IDLE
  - Outputs: all 0.
  - GO=1: n_q ← N, go to LOAD.
  - Otherwise stay in IDLE; n_q holds.
- LOAD
  - Outputs: CNT_LD=1, CNT_CE=1, REG_LD=1, REG_SEL=0, BUSY=1.
  - Always go to CHECK.
- CHECK
  - Outputs: BUSY=1; no enables asserted.
  - Transition priority: n_q > MAX_N → ERR; else CNT_Q > 1 (unsigned) → MULT; else → DONE.
- MULT
  - Outputs: REG_LD=1, REG_SEL=1, CNT_CE=1, CNT_LD=0, BUSY=1.
  - The product register multiplies by the pre-decrement Q while the counter decrements on the same edge.
  - Always go to CHECK.
- DONE
  - Outputs: DONE=1, OE=1.
  - Stay while GO=1; go to IDLE when GO=0.
- ERR
  - Outputs: ERROR=1.
  - Stay while GO=1; go to IDLE when GO=0.
- CNT_UD is 0 in every state.
- N and GO changes outside IDLE are ignored.
- N=0 or N=1: CHECK sees Q ≤ 1 and goes to DONE with the product left at 1 (0! = 1! = 1).
- All comparisons are unsigned and Data_width bits wide; no arithmetic wraps inside this block.

## Timing
- RST=1 at an edge forces IDLE and n_q=0. In the next cycle all outputs are 0, including mid-computation; counter and product register contents are not this block's concern.
- Cycle 0 is the edge where GO=1 is sampled in IDLE.
- LOAD occupies cycle 1 and CHECK cycle 2. The counter holds n_q during the first CHECK.
- Each MULT/CHECK pair adds 2 cycles. MULT executes max(n_q−1, 0) times.
- DONE is entered at cycle 2·n_q+1 for 2 ≤ n_q ≤ MAX_N, and at cycle 3 for n_q ≤ 1.
- ERR is entered at cycle 3 for n_q > MAX_N. No MULT occurs and the product register holds 1.
- Back-to-back runs need GO low for at least one cycle in DONE/ERR, then GO high in IDLE. The minimum restart gap is 2 cycles after DONE is entered.
- GO held high through DONE keeps DONE asserted indefinitely, with no restart.

## Test plan
- Reset: assert RST for 2 cycles with GO=1 → IDLE, all outputs 0, no LOAD while RST=1.
- N=5 with a behavioural down-counter and product register attached, GO held high:
  - LOAD at cycle 1, CNT_CE pulses at cycles 1,3,5,7,9.
  - DONE at cycle 11, product = 120, CNT_Q = 1.
  - GO dropped → IDLE next cycle.
- N=0, then N=1 → DONE at cycle 3, zero MULT cycles, product = 1, OE=1.
- N=13 (MAX_N=12) → ERR at cycle 3, ERROR=1, no REG_LD with REG_SEL=1. GO low → IDLE.
- N=12 → DONE at cycle 25 after 11 MULT cycles, CNT_UD=0 throughout. N=7 applied mid-run does not alter CNT_D.
- RST at cycle 6 of an N=5 run → IDLE at cycle 7, all outputs 0. A fresh GO with N=3 → DONE at cycle 7 of the new run, product = 6.
